// File: rtl/prio_mux6_reg_pkg.sv
`default_nettype none
// ============================================================================
// prio_mux6_reg_pkg : shared width default and source-index encoding
// Revision: 1.0
// ============================================================================
package prio_mux6_reg_pkg;

    localparam int DEF_WIDTH = 4;

    typedef logic [2:0] src_t;

    localparam src_t SRC_A    = 3'd0;
    localparam src_t SRC_B    = 3'd1;
    localparam src_t SRC_C    = 3'd2;
    localparam src_t SRC_D    = 3'd3;
    localparam src_t SRC_E    = 3'd4;
    localparam src_t SRC_F    = 3'd5;
    localparam src_t SRC_NONE = 3'd7;

endpackage
`default_nettype wire

// File: rtl/prio_sel6.sv
`default_nettype none
// ============================================================================
// prio_sel6 : combinational six-way fixed-priority selector
// Revision: 1.0
// ============================================================================
module prio_sel6
    import prio_mux6_reg_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    input  logic [WIDTH-1:0] e,
    input  logic [WIDTH-1:0] f,
    input  logic             sel1,
    input  logic             sel2,
    input  logic             sel3,
    input  logic             sel4,
    input  logic             sel5,
    output logic [WIDTH-1:0] nxt_data,
    output src_t             nxt_src
);

    // Nested if/else keeps lower-priority selects out of the decision once a
    // higher one is asserted, so an unknown there cannot reach the output.
    always_comb begin
        nxt_data = f;
        nxt_src  = SRC_F;
        if (sel1) begin
            nxt_data = a;
            nxt_src  = SRC_A;
        end else if (sel2) begin
            if (sel3) begin
                nxt_data = b;
                nxt_src  = SRC_B;
            end else begin
                nxt_data = c;
                nxt_src  = SRC_C;
            end
        end else if (sel4) begin
            nxt_data = d;
            nxt_src  = SRC_D;
        end else if (sel5) begin
            nxt_data = e;
            nxt_src  = SRC_E;
        end
    end

endmodule
`default_nettype wire

// File: rtl/prio_mux6_reg.sv
`default_nettype none
// ============================================================================
// prio_mux6_reg : six-input priority mux with registered data and source index
// Revision: 1.0
// ============================================================================
module prio_mux6_reg
    import prio_mux6_reg_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    input  logic [WIDTH-1:0] e,
    input  logic [WIDTH-1:0] f,
    input  logic             sel1,
    input  logic             sel2,
    input  logic             sel3,
    input  logic             sel4,
    input  logic             sel5,
    output logic [WIDTH-1:0] g,
    output logic [2:0]       src
);

    logic [WIDTH-1:0] w_nxt_data;
    src_t             w_nxt_src;
    logic [WIDTH-1:0] r_g;
    src_t             r_src;

    prio_sel6 #(
        .WIDTH (WIDTH)
    ) u_sel (
        .a        (a),
        .b        (b),
        .c        (c),
        .d        (d),
        .e        (e),
        .f        (f),
        .sel1     (sel1),
        .sel2     (sel2),
        .sel3     (sel3),
        .sel4     (sel4),
        .sel5     (sel5),
        .nxt_data (w_nxt_data),
        .nxt_src  (w_nxt_src)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_g   <= '0;
            r_src <= SRC_NONE;
        end else begin
            r_g   <= w_nxt_data;
            r_src <= w_nxt_src;
        end
    end

    assign g   = r_g;
    assign src = r_src;

endmodule
`default_nettype wire

// File: tb/tb_prio_mux6_reg.sv
`default_nettype none
// ============================================================================
// tb_prio_mux6_reg : directed and randomized checks against a priority model
// Revision: 1.0
// ============================================================================
module tb_prio_mux6_reg;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic [3:0] a, b, c, d, e, f;
    logic       sel1, sel2, sel3, sel4, sel5;
    logic [3:0] g;
    logic [2:0] src;

    int tests = 0;
    int fails = 0;

    prio_mux6_reg #(.WIDTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .b     (b),
        .c     (c),
        .d     (d),
        .e     (e),
        .f     (f),
        .sel1  (sel1),
        .sel2  (sel2),
        .sel3  (sel3),
        .sel4  (sel4),
        .sel5  (sel5),
        .g     (g),
        .src   (src)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: the first asserted rule in the priority list names the source.
    task automatic model(output logic [3:0] mg, output logic [2:0] ms);
        logic [3:0] data [6];
        logic       hit  [5];
        data = '{a, b, c, d, e, f};
        hit  = '{sel1, sel2 && sel3, sel2 && !sel3, sel4, sel5};
        ms = 3'd5;
        for (int i = 4; i >= 0; i--)
            if (hit[i]) ms = 3'(i);
        mg = data[ms];
    endtask

    task automatic set_sel(input logic [4:0] s);
        {sel1, sel2, sel3, sel4, sel5} = s;
    endtask

    task automatic tick();
        logic [3:0] mg;
        logic [2:0] ms;
        @(posedge clk);
        model(mg, ms);
        #1;
        check("model_g", g, mg);
        check("model_src", {1'b0, src}, {1'b0, ms});
    endtask

    task automatic tick_lit(input string name, input logic [3:0] eg, input logic [2:0] es);
        tick();
        check({name, "_g"}, g, eg);
        check({name, "_src"}, {1'b0, src}, {1'b0, es});
    endtask

    initial begin
        a = 4'hA; b = 4'hB; c = 4'hC; d = 4'hD; e = 4'hE; f = 4'hF;
        set_sel(5'b00000);

        #2 rst_n = 1'b0;
        #1;
        check("async_reset_g", g, 4'h0);
        check("async_reset_src", {1'b0, src}, 4'h7);
        @(posedge clk);
        #1;
        check("reset_hold_g", g, 4'h0);
        check("reset_hold_src", {1'b0, src}, 4'h7);
        #2 rst_n = 1'b1;

        set_sel(5'b10000); tick_lit("first_edge_a", 4'hA, 3'd0);
        set_sel(5'b01100); tick_lit("group_b", 4'hB, 3'd1);
        set_sel(5'b01000); tick_lit("group_c", 4'hC, 3'd2);
        set_sel(5'b00010); tick_lit("sel4_d", 4'hD, 3'd3);
        set_sel(5'b00001); tick_lit("sel5_e", 4'hE, 3'd4);
        set_sel(5'b00000); tick_lit("default_f", 4'hF, 3'd5);

        set_sel(5'b11011); tick_lit("ovl_sel1_wins", 4'hA, 3'd0);
        set_sel(5'b01010); tick_lit("ovl_c_over_d", 4'hC, 3'd2);
        set_sel(5'b00011); tick_lit("ovl_d_over_e", 4'hD, 3'd3);
        set_sel(5'b00100); tick_lit("sel3_alone_f", 4'hF, 3'd5);

        // Select change between edges must not reach the output early.
        set_sel(5'b10000);
        #3;
        check("latency_hold_g", g, 4'hF);
        check("latency_hold_src", {1'b0, src}, 4'h5);
        tick_lit("latency_update", 4'hA, 3'd0);

        set_sel(5'b00001); tick_lit("pre_reset_e", 4'hE, 3'd4);
        #3 rst_n = 1'b0;
        #1;
        check("midcycle_reset_g", g, 4'h0);
        check("midcycle_reset_src", {1'b0, src}, 4'h7);
        #2 rst_n = 1'b1;
        tick_lit("post_reset_e", 4'hE, 3'd4);

        for (int n = 0; n < 400; n++) begin
            a = 4'($urandom); b = 4'($urandom); c = 4'($urandom);
            d = 4'($urandom); e = 4'($urandom); f = 4'($urandom);
            set_sel(5'($urandom));
            tick();
            check("no_src6", {1'b0, src == 3'd6 ? 3'd6 : 3'd0}, 4'h0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
